// File: rtl/bus_master_arbiter.sv
// Two-port arbiter that acquires 68000 bus mastership (BR/BG/BGACK) and feeds the
// shared bus-cycle engine one command at a time, releasing the bus after an idle hold.
module bus_master_arbiter #(
  parameter int unsigned CMD_W    = 46,
  parameter int unsigned GRANT_TO = 255,
  parameter int unsigned HOLD_CYC = 4
) (
  input  logic             sys_clk,
  input  logic             nSYS_RESET,
  input  logic             mc_clk_rising,
  input  logic             mc_clk_falling,
  input  logic             amiga_rst_n,
  input  logic             bg_n_sync,
  input  logic             bus_idle,
  input  logic [1:0]       req_valid,
  input  logic [CMD_W-1:0] req_cmd0,
  input  logic [CMD_W-1:0] req_cmd1,
  output logic [1:0]       req_ready,
  output logic [1:0]       req_done,
  output logic [15:0]      req_rdata,
  output logic             req_berr,
  output logic             eng_start,
  output logic [CMD_W-1:0] eng_cmd,
  input  logic             eng_done,
  input  logic [15:0]      eng_rdata,
  input  logic             eng_berr,
  output logic             br_drive,
  output logic             bgack_drive,
  output logic             own_bus
);

  localparam logic [7:0] GrantLast = 8'(GRANT_TO - 1);
  localparam logic [3:0] HoldMax   = 4'(HOLD_CYC);

  typedef enum logic [2:0] {
    StIdle,
    StWaitGrant,
    StTakeBus,
    StIssue,
    StBusy,
    StOwn,
    StRelease
  } state_e;

  state_e           state_q, state_d;
  logic             rr_last_q, rr_last_d;
  logic             owner_q, owner_d;
  logic             pending_q, pending_d;
  logic [7:0]       grant_cnt_q, grant_cnt_d;
  logic [3:0]       hold_cnt_q, hold_cnt_d;
  logic [CMD_W-1:0] eng_cmd_q, eng_cmd_d;
  logic             br_q, br_d;
  logic             bgack_q, bgack_d;
  logic             start_q, start_d;
  logic [1:0]       ready_q, ready_d;
  logic [1:0]       done_q, done_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             berr_q, berr_d;

  logic             win;
  logic [CMD_W-1:0] win_cmd;
  logic [1:0]       owner_oh;

  // The falling strobe is part of the bus-timing bundle but not needed here.
  logic unused_falling;
  assign unused_falling = mc_clk_falling;

  // Single requester wins outright; on contention the port not served last wins.
  always_comb begin
    if (req_valid == 2'b10) begin
      win = 1'b1;
    end else if (req_valid == 2'b01) begin
      win = 1'b0;
    end else begin
      win = ~rr_last_q;
    end
    win_cmd  = win ? req_cmd1 : req_cmd0;
    owner_oh = owner_q ? 2'b10 : 2'b01;
  end

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    owner_d     = owner_q;
    pending_d   = pending_q;
    grant_cnt_d = grant_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    eng_cmd_d   = eng_cmd_q;
    br_d        = br_q;
    bgack_d     = bgack_q;
    start_d     = 1'b0;
    ready_d     = 2'b00;
    done_d      = 2'b00;
    rdata_d     = rdata_q;
    berr_d      = berr_q;

    if (!amiga_rst_n) begin
      state_d = StIdle;
      br_d    = 1'b0;
      bgack_d = 1'b0;
      if (pending_q) begin
        done_d    = owner_oh;
        berr_d    = 1'b1;
        rdata_d   = 16'h0000;
        pending_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req_valid) begin
            eng_cmd_d   = win_cmd;
            owner_d     = win;
            rr_last_d   = win;
            pending_d   = 1'b1;
            ready_d     = win ? 2'b10 : 2'b01;
            br_d        = 1'b1;
            grant_cnt_d = 8'd0;
            state_d     = StWaitGrant;
          end
        end
        StWaitGrant: begin
          if (!bg_n_sync) begin
            state_d = StTakeBus;
          end else if (mc_clk_rising) begin
            if (grant_cnt_q == GrantLast) begin
              br_d      = 1'b0;
              done_d    = owner_oh;
              berr_d    = 1'b1;
              rdata_d   = 16'h0000;
              pending_d = 1'b0;
              state_d   = StIdle;
            end else if (grant_cnt_q != 8'hFF) begin
              grant_cnt_d = grant_cnt_q + 8'd1;
            end
          end
        end
        StTakeBus: begin
          // No timeout here: the current master must finish its cycle first.
          if (mc_clk_rising && bus_idle) begin
            bgack_d = 1'b1;
            br_d    = 1'b0;
            start_d = 1'b1;
            state_d = StIssue;
          end
        end
        StIssue: begin
          state_d = StBusy;
        end
        StBusy: begin
          if (eng_done) begin
            done_d     = owner_oh;
            rdata_d    = eng_rdata;
            berr_d     = eng_berr;
            hold_cnt_d = 4'd0;
            pending_d  = 1'b0;
            state_d    = StOwn;
          end
        end
        StOwn: begin
          if (|req_valid) begin
            eng_cmd_d = win_cmd;
            owner_d   = win;
            rr_last_d = win;
            pending_d = 1'b1;
            ready_d   = win ? 2'b10 : 2'b01;
            start_d   = 1'b1;
            state_d   = StIssue;
          end else if (hold_cnt_q >= HoldMax) begin
            state_d = StRelease;
          end else if (mc_clk_rising) begin
            hold_cnt_d = hold_cnt_q + 4'd1;
          end
        end
        StRelease: begin
          if (mc_clk_rising) begin
            bgack_d = 1'b0;
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge nSYS_RESET) begin
    if (!nSYS_RESET) begin
      state_q     <= StIdle;
      rr_last_q   <= 1'b1;
      owner_q     <= 1'b0;
      pending_q   <= 1'b0;
      grant_cnt_q <= 8'd0;
      hold_cnt_q  <= 4'd0;
      eng_cmd_q   <= '0;
      br_q        <= 1'b0;
      bgack_q     <= 1'b0;
      start_q     <= 1'b0;
      ready_q     <= 2'b00;
      done_q      <= 2'b00;
      rdata_q     <= 16'h0000;
      berr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      owner_q     <= owner_d;
      pending_q   <= pending_d;
      grant_cnt_q <= grant_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      eng_cmd_q   <= eng_cmd_d;
      br_q        <= br_d;
      bgack_q     <= bgack_d;
      start_q     <= start_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      berr_q      <= berr_d;
    end
  end

  assign req_ready   = ready_q;
  assign req_done    = done_q;
  assign req_rdata   = rdata_q;
  assign req_berr    = berr_q;
  assign eng_start   = start_q;
  assign eng_cmd     = eng_cmd_q;
  assign br_drive    = br_q;
  assign bgack_drive = bgack_q;
  assign own_bus     = bgack_q;

endmodule
